floor_request_manager: RTL and testbench

- Front end of the elevator controller. Latches hall-call and cab-destination button presses into the 12-bit FloorsRequested / FloorDestinations vectors consumed by the direction scoring logic.
- Watches the returned 8-bit half-floor positions. When a car has stopped at a pending floor, it holds the doors open for a dwell time and then clears that floor's request bits.
- Two identical car channels:
  - left car: request bits 11:6, position bits 7:4;
  - right car: request bits 5:0, position bits 3:0.

---
 rtl/elevator_pkg.sv | 42 ++++
 rtl/car_service_fsm.sv | 135 +++++++++++++
 rtl/floor_request_manager.sv | 53 +++++
 tb/tb_floor_request_manager.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared elevator types and half-floor position decode helpers.
// Imported by the per-car service FSM and the request manager top.
package elevator_pkg;

  localparam int NUM_FLOORS = 6;
  localparam int POS_W = 4;
  localparam int FLOOR_W = $clog2(NUM_FLOORS);

  localparam logic [POS_W-1:0] MAX_CODE =
    POS_W'(2 * (NUM_FLOORS - 1));

  typedef enum logic [1:0] {
    TRAVEL = 2'd0,
    SETTLE = 2'd1,
    DOOR   = 2'd2
  } car_state_t;

  function automatic logic is_whole_floor(
    input logic [POS_W-1:0] code
  );
    return !code[0] && (code <= MAX_CODE);
  endfunction

  function automatic logic [FLOOR_W-1:0] floor_of(
    input logic [POS_W-1:0] code
  );
    return FLOOR_W'(code >> 1);
  endfunction

  // One-hot floor select; all zero when the car is between floors.
  function automatic logic [NUM_FLOORS-1:0] floor_mask(
    input logic [POS_W-1:0] code
  );
    logic [NUM_FLOORS-1:0] m;
    m = '0;
    if (is_whole_floor(code)) begin
      m = NUM_FLOORS'(1) << floor_of(code);
    end
    return m;
  endfunction

endpackage

// File: rtl/car_service_fsm.sv
// One elevator car: button latching, stop detection, door dwell
// and clearing of the serviced floor's request bits.
module car_service_fsm
  import elevator_pkg::*;
#(
  parameter int SETTLE_CYCLES = 5,
  parameter int DOOR_CYCLES = 60
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] btn_request,
  input  logic [NUM_FLOORS-1:0] btn_dest,
  input  logic [POS_W-1:0]      pos,
  output logic [NUM_FLOORS-1:0] requested,
  output logic [NUM_FLOORS-1:0] destinations,
  output logic                  door_open,
  output logic                  serviced,
  output logic                  pos_fault
);

  localparam int MAX_CYC =
    (SETTLE_CYCLES > DOOR_CYCLES) ? SETTLE_CYCLES : DOOR_CYCLES;
  localparam int CNT_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST =
    CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DOOR_LAST =
    CNT_W'(DOOR_CYCLES - 1);

  car_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [POS_W-1:0] code_q, code_d;

  logic [NUM_FLOORS-1:0] req_prev_q, dest_prev_q;
  logic [NUM_FLOORS-1:0] req_q, req_d;
  logic [NUM_FLOORS-1:0] dest_q, dest_d;
  logic [NUM_FLOORS-1:0] pos_mask, svc_mask;
  logic [NUM_FLOORS-1:0] clr, ignore;
  logic [NUM_FLOORS-1:0] req_edge, dest_edge;

  logic serviced_q, svc_d;
  logic fault_q, fault_set;
  logic pending, moved;

  assign pos_mask = floor_mask(pos);
  assign svc_mask = floor_mask(code_q);
  assign pending = |((req_q | dest_q) & pos_mask);
  assign moved = (pos != code_q);

  // Next state, counter and the per-floor clear/ignore masks.
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    code_d = code_q;
    clr = '0;
    ignore = '0;
    svc_d = 1'b0;
    fault_set = 1'b0;
    unique case (state_q)
      TRAVEL: begin
        if (pending) begin
          state_d = SETTLE;
          cnt_d = '0;
          code_d = pos;
        end
      end
      SETTLE: begin
        if (moved) begin
          state_d = TRAVEL;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = DOOR;
          cnt_d = '0;
          clr = svc_mask;
          svc_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DOOR: begin
        ignore = svc_mask;
        if (moved) begin
          state_d = TRAVEL;
          fault_set = 1'b1;
        end else if (cnt_q == DOOR_LAST) begin
          state_d = TRAVEL;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = TRAVEL;
      end
    endcase
  end

  // Rising edges set bits; a same-cycle clear takes priority.
  always_comb begin
    req_edge = btn_request & ~req_prev_q & ~ignore;
    dest_edge = btn_dest & ~dest_prev_q & ~ignore;
    req_d = (req_q | req_edge) & ~clr;
    dest_d = (dest_q | dest_edge) & ~clr;
  end

  // State, counters, latched vectors and sticky fault.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= TRAVEL;
      cnt_q <= '0;
      code_q <= '0;
      req_prev_q <= '0;
      dest_prev_q <= '0;
      req_q <= '0;
      dest_q <= '0;
      serviced_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      code_q <= code_d;
      req_prev_q <= btn_request;
      dest_prev_q <= btn_dest;
      req_q <= req_d;
      dest_q <= dest_d;
      serviced_q <= svc_d;
      fault_q <= fault_q | fault_set;
    end
  end

  assign requested = req_q;
  assign destinations = dest_q;
  assign serviced = serviced_q;
  assign pos_fault = fault_q;
  // Drops in the very cycle the car moves, not one cycle later.
  assign door_open = (state_q == DOOR) && !moved;

endmodule

// File: rtl/floor_request_manager.sv
// Elevator front end: two independent car service channels.
// Left car owns the upper bus halves, right car the lower.
module floor_request_manager
  import elevator_pkg::*;
#(
  parameter int SETTLE_CYCLES = 5,
  parameter int DOOR_CYCLES = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] btn_request,
  input  logic [11:0] btn_dest,
  input  logic [7:0]  half_elevatorPositions,
  output logic [11:0] FloorsRequested,
  output logic [11:0] FloorDestinations,
  output logic [1:0]  door_open,
  output logic [1:0]  serviced,
  output logic [1:0]  pos_fault
);

  car_service_fsm #(
    .SETTLE_CYCLES(SETTLE_CYCLES),
    .DOOR_CYCLES(DOOR_CYCLES)
  ) u_left (
    .clk(clk),
    .rst(rst),
    .btn_request(btn_request[11:6]),
    .btn_dest(btn_dest[11:6]),
    .pos(half_elevatorPositions[7:4]),
    .requested(FloorsRequested[11:6]),
    .destinations(FloorDestinations[11:6]),
    .door_open(door_open[1]),
    .serviced(serviced[1]),
    .pos_fault(pos_fault[1])
  );

  car_service_fsm #(
    .SETTLE_CYCLES(SETTLE_CYCLES),
    .DOOR_CYCLES(DOOR_CYCLES)
  ) u_right (
    .clk(clk),
    .rst(rst),
    .btn_request(btn_request[5:0]),
    .btn_dest(btn_dest[5:0]),
    .pos(half_elevatorPositions[3:0]),
    .requested(FloorsRequested[5:0]),
    .destinations(FloorDestinations[5:0]),
    .door_open(door_open[0]),
    .serviced(serviced[0]),
    .pos_fault(pos_fault[0])
  );

endmodule

// File: tb/tb_floor_request_manager.sv
// Directed bench for floor_request_manager.
// Inputs change 1 time unit after posedge; outputs sampled before next.
module tb_floor_request_manager;
  import elevator_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [11:0] btn_request = '0;
  logic [11:0] btn_dest = '0;
  logic [7:0] pos = '0;
  logic [11:0] FloorsRequested;
  logic [11:0] FloorDestinations;
  logic [1:0] door_open;
  logic [1:0] serviced;
  logic [1:0] pos_fault;

  int checks = 0;
  int errors = 0;
  int n;

  floor_request_manager dut (
    .clk(clk),
    .rst(rst),
    .btn_request(btn_request),
    .btn_dest(btn_dest),
    .half_elevatorPositions(pos),
    .FloorsRequested(FloorsRequested),
    .FloorDestinations(FloorDestinations),
    .door_open(door_open),
    .serviced(serviced),
    .pos_fault(pos_fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [11:0] obs,
                       input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int k);
    repeat (k) tick();
  endtask

  task automatic wait_right_close();
    for (int i = 0; i < 100; i++) begin
      if (!door_open[0]) break;
      tick();
    end
  endtask

  task automatic wait_left_close();
    for (int i = 0; i < 100; i++) begin
      if (!door_open[1]) break;
      tick();
    end
  endtask

  initial begin
    #12;
    check("rst_fr", FloorsRequested, 12'h000);
    check("rst_fd", FloorDestinations, 12'h000);
    check("rst_door", 12'(door_open), 12'h0);
    check("rst_fault", 12'(pos_fault), 12'h0);
    rst = 1'b0;
    tick();

    // Right car: hall call at floor 3, then stop there.
    btn_request[3] = 1'b1;
    tick();
    btn_request = '0;
    check("s1_latch", FloorsRequested, 12'h008);
    pos = 8'h06;
    ticks(5);
    check("s1_settling", 12'(door_open), 12'h0);
    check("s1_still_req", FloorsRequested, 12'h008);
    tick();
    check("s1_cleared", FloorsRequested, 12'h000);
    check("s1_door", 12'(door_open), 12'h1);
    check("s1_pulse", 12'(serviced), 12'h1);
    n = 0;
    for (int i = 0; i < 80; i++) begin
      if (!door_open[0]) break;
      n++;
      tick();
      if (i == 0) check("s1_pulse_end", 12'(serviced), 12'h0);
    end
    check("s1_door_len", 12'(n), 12'd60);

    // Left car: destination floor 2, aborted settle then real stop.
    btn_dest[8] = 1'b1;
    tick();
    btn_dest = '0;
    check("s2_latch", FloorDestinations, 12'h100);
    pos = 8'h46;
    ticks(3);
    pos = 8'h56;
    ticks(2);
    check("s2_no_svc", FloorDestinations, 12'h100);
    check("s2_no_door", 12'(door_open), 12'h0);
    pos = 8'h46;
    ticks(5);
    check("s2_settling", 12'(door_open), 12'h0);
    tick();
    check("s2_cleared", FloorDestinations, 12'h000);
    check("s2_door", 12'(door_open), 12'h2);
    check("s2_pulse", 12'(serviced), 12'h2);

    // Presses during left DOOR: own floor dropped, other kept.
    btn_request[8] = 1'b1;
    btn_request[10] = 1'b1;
    tick();
    btn_request = '0;
    check("s3_mask", FloorsRequested, 12'h400);
    check("s3_door_held", 12'(door_open), 12'h2);
    wait_left_close();
    check("s3_closed", 12'(door_open), 12'h0);
    check("s3_fr", FloorsRequested, 12'h400);

    // Right car stops at floor 1, then drifts with doors open.
    btn_request[1] = 1'b1;
    tick();
    btn_request = '0;
    check("s4_latch", FloorsRequested, 12'h402);
    pos = 8'h42;
    ticks(6);
    check("s4_door", 12'(door_open), 12'h1);
    ticks(19);
    check("s4_door_c19", 12'(door_open), 12'h1);
    pos = 8'h43;
    #1;
    check("s4_abort_comb", 12'(door_open), 12'h0);
    tick();
    check("s4_fault", 12'(pos_fault), 12'h1);
    check("s4_fr", FloorsRequested, 12'h400);
    pos = 8'h42;
    ticks(3);
    check("s4_sticky", 12'(pos_fault), 12'h1);
    check("s4_no_reopen", 12'(door_open), 12'h0);

    // Held destination at floor 0 is cleared and not re-latched.
    pos = 8'h40;
    tick();
    btn_dest[0] = 1'b1;
    tick();
    check("s5_latch", FloorDestinations, 12'h001);
    ticks(5);
    check("s5_settling", 12'(door_open), 12'h0);
    tick();
    check("s5_cleared", FloorDestinations, 12'h000);
    check("s5_door", 12'(door_open), 12'h1);
    wait_right_close();
    ticks(3);
    check("s5_held_clear", FloorDestinations, 12'h000);
    check("s5_no_resvc", 12'(serviced), 12'h0);
    btn_dest = '0;
    tick();
    btn_dest[0] = 1'b1;
    tick();
    btn_dest = '0;
    check("s5_repress", FloorDestinations, 12'h001);

    // Re-service, then async reset at door counter 30.
    ticks(6);
    check("s6_door", 12'(door_open), 12'h1);
    ticks(30);
    check("s6_door_c30", 12'(door_open), 12'h1);
    #2;
    rst = 1'b1;
    #1;
    check("s6_rst_door", 12'(door_open), 12'h0);
    check("s6_rst_fr", FloorsRequested, 12'h000);
    check("s6_rst_fd", FloorDestinations, 12'h000);
    check("s6_rst_fault", 12'(pos_fault), 12'h0);
    check("s6_rst_svc", 12'(serviced), 12'h0);
    check("s6_rst_state", 12'(dut.u_right.state_q), 12'(TRAVEL));
    @(negedge clk);
    rst = 1'b0;
    ticks(3);
    check("s6_post_door", 12'(door_open), 12'h0);
    check("s6_post_fr", FloorsRequested, 12'h000);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
